// File: rtl/jtag_vector_serializer_pkg.sv
// Shared JTAG package: vector width and TAP-state enums, packet payload,
// serializer FSM states and the IEEE 1149.1 TAP transition function.
package jtag_vector_serializer_pkg;

  localparam int unsigned JTAG_MAX_VECTOR_WIDTH = 32;
  localparam int unsigned JTAG_TAP_STATE_WIDTH  = 4;
  localparam int unsigned JTAG_WIDTH_BITS       = 6;

  typedef enum logic [JTAG_WIDTH_BITS-1:0] {
    JTAG_WIDTH_8  = 6'd8,
    JTAG_WIDTH_16 = 6'd16,
    JTAG_WIDTH_24 = 6'd24,
    JTAG_WIDTH_32 = 6'd32
  } jtag_width_e;

  typedef enum logic [JTAG_TAP_STATE_WIDTH-1:0] {
    jtagResetState     = 4'd0,
    jtagIdleState      = 4'd1,
    jtagDrScanState    = 4'd2,
    jtagIrScanState    = 4'd3,
    jtagCaptureIrState = 4'd4,
    jtagShiftIrState   = 4'd5,
    jtagExit1IrState   = 4'd6,
    jtagPauseIrState   = 4'd7,
    jtagExit2IrState   = 4'd8,
    jtagUpdateIrState  = 4'd9,
    jtagCaptureDrState = 4'd10,
    jtagShiftDrState   = 4'd11,
    jtagExit1DrState   = 4'd12,
    jtagPauseDrState   = 4'd13,
    jtagExit2DrState   = 4'd14,
    jtagUpdateDrState  = 4'd15
  } jtag_tap_state_e;

  typedef enum logic [2:0] {
    SER_IDLE = 3'd0,
    SER_LOW  = 3'd1,
    SER_HIGH = 3'd2,
    SER_DONE = 3'd3,
    SER_TRST = 3'd4
  } ser_state_e;

  typedef struct packed {
    logic [JTAG_MAX_VECTOR_WIDTH-1:0] vec;
    logic [JTAG_MAX_VECTOR_WIDTH-1:0] tmsBits;
    logic [JTAG_WIDTH_BITS-1:0]       width;
  } jtag_packet_t;

  // Only the four enumerated widths produce TCK activity.
  function automatic logic jtagIsLegalWidth(input logic [JTAG_WIDTH_BITS-1:0] w);
    return (w == JTAG_WIDTH_8)  || (w == JTAG_WIDTH_16) ||
           (w == JTAG_WIDTH_24) || (w == JTAG_WIDTH_32);
  endfunction

  // TAP controller next state for one rising TCK with the given TMS.
  function automatic jtag_tap_state_e jtagNextTapState(input jtag_tap_state_e s, input logic tms);
    jtag_tap_state_e n;
    n = jtagResetState;
    case (s)
      jtagResetState:     n = tms ? jtagResetState   : jtagIdleState;
      jtagIdleState:      n = tms ? jtagDrScanState  : jtagIdleState;
      jtagDrScanState:    n = tms ? jtagIrScanState  : jtagCaptureDrState;
      jtagIrScanState:    n = tms ? jtagResetState   : jtagCaptureIrState;
      jtagCaptureIrState: n = tms ? jtagExit1IrState : jtagShiftIrState;
      jtagShiftIrState:   n = tms ? jtagExit1IrState : jtagShiftIrState;
      jtagExit1IrState:   n = tms ? jtagUpdateIrState : jtagPauseIrState;
      jtagPauseIrState:   n = tms ? jtagExit2IrState : jtagPauseIrState;
      jtagExit2IrState:   n = tms ? jtagUpdateIrState : jtagShiftIrState;
      jtagUpdateIrState:  n = tms ? jtagDrScanState  : jtagIdleState;
      jtagCaptureDrState: n = tms ? jtagExit1DrState : jtagShiftDrState;
      jtagShiftDrState:   n = tms ? jtagExit1DrState : jtagShiftDrState;
      jtagExit1DrState:   n = tms ? jtagUpdateDrState : jtagPauseDrState;
      jtagPauseDrState:   n = tms ? jtagExit2DrState : jtagPauseDrState;
      jtagExit2DrState:   n = tms ? jtagUpdateDrState : jtagShiftDrState;
      jtagUpdateDrState:  n = tms ? jtagDrScanState  : jtagIdleState;
      default:            n = jtagResetState;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_vector_serializer_if.sv
// Packet request / response bundle between a JTAG controller and the serializer.
interface jtag_vector_serializer_if
  import jtag_vector_serializer_pkg::*;
();

  logic                             packetValid;
  logic                             packetReady;
  logic [JTAG_MAX_VECTOR_WIDTH-1:0] jtagTestVector;
  logic [JTAG_MAX_VECTOR_WIDTH-1:0] jtagTms;
  logic [JTAG_WIDTH_BITS-1:0]       vectorWidth;
  logic                             respValid;
  logic [JTAG_MAX_VECTOR_WIDTH-1:0] capturedTdo;
  logic                             widthError;

  modport master (
    output packetValid, jtagTestVector, jtagTms, vectorWidth,
    input  packetReady, respValid, capturedTdo, widthError
  );

  modport slave (
    input  packetValid, jtagTestVector, jtagTms, vectorWidth,
    output packetReady, respValid, capturedTdo, widthError
  );

endinterface

// File: rtl/jtag_tap_state_tracker.sv
// Mirrors the target's TAP controller: advances once per rising TCK strobe.
module jtag_tap_state_tracker
  import jtag_vector_serializer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_advance,
  input  logic            i_tms,
  input  logic            i_force,
  output jtag_tap_state_e o_tapState
);

  jtag_tap_state_e r_state;

  // Forced reset (TRST) wins over a TCK strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= jtagResetState;
    end else if (i_force) begin
      r_state <= jtagResetState;
    end else if (i_advance) begin
      r_state <= jtagNextTapState(r_state, i_tms);
    end
  end

  assign o_tapState = r_state;

endmodule

// File: rtl/jtag_vector_serializer.sv
// Serializes one JTAG packet onto TCK/TMS/TDI and captures TDO.
// Optional feature macro: JTAG_TRST_EN adds trstReq/trstN test-reset pulsing.
module jtag_vector_serializer
  import jtag_vector_serializer_pkg::*;
#(
  parameter int unsigned TCK_HALF_PERIOD = 2,
  parameter int unsigned MAX_WIDTH       = JTAG_MAX_VECTOR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  jtag_vector_serializer_if.slave    bus,
  output logic                       tck,
  output logic                       tms,
  output logic                       tdi,
  input  logic                       tdo,
  output logic [JTAG_TAP_STATE_WIDTH-1:0] tapState
`ifdef JTAG_TRST_EN
  ,
  input  logic                       trstReq,
  output logic                       trstN
`endif
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned IDX_W = $clog2(MAX_WIDTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TCK_HALF_PERIOD - 1);
`ifdef JTAG_TRST_EN
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(2 * TCK_HALF_PERIOD - 1);
`endif

  ser_state_e                       r_state;
  jtag_packet_t                     r_pkt;
  logic [CNT_W-1:0]                 r_phaseCnt;
  logic [IDX_W-1:0]                 r_bitIdx;
  logic [JTAG_MAX_VECTOR_WIDTH-1:0] r_cap;
  logic                             r_badWidth;
  logic                             r_packetReady;
  logic                             r_respValid;
  logic                             r_widthError;
  logic                             r_tck;
  logic                             r_tms;
  logic                             r_tdi;
`ifdef JTAG_TRST_EN
  logic                             r_trstN;
`endif

  logic                             w_phaseEnd;
  logic                             w_lastBit;
  logic [IDX_W-1:0]                 w_nextIdx;
  logic                             w_tapAdvance;
  logic                             w_tapForce;
  jtag_tap_state_e                  w_tapState;

  // Phase bookkeeping shared by the LOW/HIGH states.
  assign w_phaseEnd   = (r_phaseCnt == HALF_LAST);
  assign w_lastBit    = (JTAG_WIDTH_BITS'(r_bitIdx) == (r_pkt.width - 6'd1));
  assign w_nextIdx    = r_bitIdx + IDX_W'(1);
  assign w_tapAdvance = (r_state == SER_LOW) && w_phaseEnd;
`ifdef JTAG_TRST_EN
  assign w_tapForce   = (r_state == SER_TRST);
`else
  assign w_tapForce   = 1'b0;
`endif

  // Serializer FSM with all pin and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SER_IDLE;
      r_pkt         <= '0;
      r_phaseCnt    <= '0;
      r_bitIdx      <= '0;
      r_cap         <= '0;
      r_badWidth    <= 1'b0;
      r_packetReady <= 1'b0;
      r_respValid   <= 1'b0;
      r_widthError  <= 1'b0;
      r_tck         <= 1'b0;
      r_tms         <= 1'b1;
      r_tdi         <= 1'b0;
`ifdef JTAG_TRST_EN
      r_trstN       <= 1'b0;
`endif
    end else begin
      r_respValid  <= 1'b0;
      r_widthError <= 1'b0;
      case (r_state)
        SER_IDLE: begin
`ifdef JTAG_TRST_EN
          r_trstN <= 1'b1;
          if (trstReq) begin
            r_state       <= SER_TRST;
            r_trstN       <= 1'b0;
            r_packetReady <= 1'b0;
            r_phaseCnt    <= '0;
          end else
`endif
          if (r_packetReady && bus.packetValid) begin
            r_packetReady <= 1'b0;
            r_pkt         <= '{vec: bus.jtagTestVector, tmsBits: bus.jtagTms,
                               width: bus.vectorWidth};
            r_bitIdx      <= '0;
            r_cap         <= '0;
            r_phaseCnt    <= '0;
            if (jtagIsLegalWidth(bus.vectorWidth)) begin
              r_state    <= SER_LOW;
              r_badWidth <= 1'b0;
              r_tms      <= bus.jtagTms[0];
              r_tdi      <= bus.jtagTestVector[0];
            end else begin
              r_state    <= SER_DONE;
              r_badWidth <= 1'b1;
            end
          end else begin
            r_packetReady <= 1'b1;
          end
        end
        SER_LOW: begin
          if (w_phaseEnd) begin
            r_state         <= SER_HIGH;
            r_phaseCnt      <= '0;
            r_tck           <= 1'b1;
            r_cap[r_bitIdx] <= tdo;
          end else begin
            r_phaseCnt <= r_phaseCnt + CNT_W'(1);
          end
        end
        SER_HIGH: begin
          if (w_phaseEnd) begin
            r_tck      <= 1'b0;
            r_phaseCnt <= '0;
            if (w_lastBit) begin
              r_state <= SER_DONE;
            end else begin
              r_state  <= SER_LOW;
              r_bitIdx <= w_nextIdx;
              r_tms    <= r_pkt.tmsBits[w_nextIdx];
              r_tdi    <= r_pkt.vec[w_nextIdx];
            end
          end else begin
            r_phaseCnt <= r_phaseCnt + CNT_W'(1);
          end
        end
        SER_DONE: begin
          r_respValid   <= 1'b1;
          r_widthError  <= r_badWidth;
          r_packetReady <= 1'b1;
          r_state       <= SER_IDLE;
        end
`ifdef JTAG_TRST_EN
        SER_TRST: begin
          if (r_phaseCnt == TRST_LAST) begin
            r_trstN <= 1'b1;
            r_state <= SER_IDLE;
          end else begin
            r_phaseCnt <= r_phaseCnt + CNT_W'(1);
          end
        end
`endif
        default: r_state <= SER_IDLE;
      endcase
    end
  end

  jtag_tap_state_tracker u_tap (
    .clk        (clk),
    .rst        (reset),
    .i_advance  (w_tapAdvance),
    .i_tms      (r_tms),
    .i_force    (w_tapForce),
    .o_tapState (w_tapState)
  );

  assign bus.packetReady = r_packetReady;
  assign bus.respValid   = r_respValid;
  assign bus.widthError  = r_widthError;
  assign bus.capturedTdo = r_cap;
  assign tck             = r_tck;
  assign tms             = r_tms;
  assign tdi             = r_tdi;
  assign tapState        = w_tapState;
`ifdef JTAG_TRST_EN
  assign trstN           = r_trstN;
`endif

endmodule

// File: tb/tb_jtag_vector_serializer.sv
// Directed bench for jtag_vector_serializer with hand-computed expectations.
module tb_jtag_vector_serializer;

  localparam int unsigned H = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tck, tms, tdi, tdo;
  logic [3:0] tapState;
`ifdef JTAG_TRST_EN
  logic       trstReq = 1'b0;
  logic       trstN;
`endif

  jtag_vector_serializer_if bus ();

  jtag_vector_serializer #(.TCK_HALF_PERIOD(H), .MAX_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo),
    .tapState (tapState)
`ifdef JTAG_TRST_EN
    ,
    .trstReq  (trstReq),
    .trstN    (trstN)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rise_cnt = 0;
  int          rise_base = 0;
  logic        tdo_loop = 1'b1;
  logic [31:0] tdo_pat = '0;
  logic [31:0] tdi_log = '0;
  logic [4:0]  bit_idx;

  // TDO source: loopback of TDI or a per-bit pattern indexed by TCK rises.
  assign bit_idx = 5'(rise_cnt - rise_base);
  assign tdo     = tdo_loop ? tdi : tdo_pat[bit_idx];

  // Log TDI at each rising TCK and count edges.
  always @(posedge tck) begin
    tdi_log[bit_idx] <= tdi;
    rise_cnt         <= rise_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50; k++) begin
      if (bus.packetReady === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("ready_before_packet", 32'(bus.packetReady), 32'd1);
  endtask

  // Issue one packet; lat = clk edges from the accept edge to respValid.
  task automatic run_packet(input logic [31:0] vec, input logic [31:0] tmsv,
                            input logic [5:0] w, input int maxc,
                            output int lat, output logic got, output logic werr,
                            output int rises);
    wait_ready();
    rise_base          = rise_cnt;
    bus.jtagTestVector = vec;
    bus.jtagTms        = tmsv;
    bus.vectorWidth    = w;
    bus.packetValid    = 1'b1;
    @(posedge clk); #1;
    bus.packetValid    = 1'b0;
    lat  = -1;
    got  = 1'b0;
    werr = 1'b0;
    for (int k = 0; k <= maxc; k++) begin
      if (bus.respValid === 1'b1) begin
        lat  = k;
        got  = 1'b1;
        werr = bus.widthError;
        break;
      end
      @(posedge clk); #1;
    end
    rises = rise_cnt - rise_base;
  endtask

  int   lat, rises, resp_seen;
  logic got, werr;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.packetValid    = 1'b0;
    bus.jtagTestVector = '0;
    bus.jtagTms        = '0;
    bus.vectorWidth    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", 32'(tck), 32'd0);
    chk("rst_tms", 32'(tms), 32'd1);
    chk("rst_tdi", 32'(tdi), 32'd0);
    chk("rst_ready", 32'(bus.packetReady), 32'd0);
    chk("rst_resp", 32'(bus.respValid), 32'd0);
    chk("rst_werr", 32'(bus.widthError), 32'd0);
    chk("rst_cap", bus.capturedTdo, 32'h0);
    chk("rst_tap", 32'(tapState), 32'd0);

    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(bus.packetReady), 32'd1);
    chk("idle_tap", 32'(tapState), 32'd0);
    chk("idle_tms", 32'(tms), 32'd1);
    chk("idle_tck", 32'(tck), 32'd0);

    // 0xA5 width 8, TMS all zero, TDO looped: Reset -> Idle.
    tdo_loop = 1'b1;
    run_packet(32'h0000_00A5, 32'h0, 6'd8, 200, lat, got, werr, rises);
    chk("a5_resp", 32'(got), 32'd1);
    chk("a5_latency", 32'(lat), 32'd33);
    chk("a5_werr", 32'(werr), 32'd0);
    chk("a5_tck_rises", 32'(rises), 32'd8);
    chk("a5_tdi_seq", {24'h0, tdi_log[7:0]}, 32'h0000_00A5);
    chk("a5_cap", bus.capturedTdo, 32'h0000_00A5);
    chk("a5_tap", 32'(tapState), 32'd1);
    @(posedge clk); #1;
    chk("a5_resp_pulse", 32'(bus.respValid), 32'd0);

    // TMS all ones from Idle: DrScan, IrScan, Reset, Reset...
    run_packet(32'h0, 32'h0000_00FF, 6'd8, 200, lat, got, werr, rises);
    chk("to_reset_latency", 32'(lat), 32'd33);
    chk("to_reset_tap", 32'(tapState), 32'd0);

    // TMS 0x02 from Reset: Idle, DrScan, CaptureDr, ShiftDr x5.
    run_packet(32'h0, 32'h0000_0002, 6'd8, 200, lat, got, werr, rises);
    chk("shiftdr_resp", 32'(got), 32'd1);
    chk("shiftdr_tap", 32'(tapState), 32'd11);
    chk("shiftdr_cap", bus.capturedTdo, 32'h0);

    // 32-bit TMS all ones from ShiftDr, TDO pattern 0xDEADBEEF.
    tdo_loop = 1'b0;
    tdo_pat  = 32'hDEAD_BEEF;
    run_packet(32'h1234_5678, 32'hFFFF_FFFF, 6'd32, 400, lat, got, werr, rises);
    chk("w32_latency", 32'(lat), 32'd129);
    chk("w32_tck_rises", 32'(rises), 32'd32);
    chk("w32_tdi_seq", tdi_log, 32'h1234_5678);
    chk("w32_cap", bus.capturedTdo, 32'hDEAD_BEEF);
    chk("w32_tap", 32'(tapState), 32'd0);

    // Width 16 back to back: upper capture bits cleared from the previous packet.
    tdo_loop = 1'b1;
    run_packet(32'h0000_5A3C, 32'h0, 6'd16, 200, lat, got, werr, rises);
    chk("w16_latency", 32'(lat), 32'd65);
    chk("w16_cap", bus.capturedTdo, 32'h0000_5A3C);
    chk("w16_tap", 32'(tapState), 32'd1);

    // Illegal width 5: immediate DONE, no TCK activity, TAP untouched.
    run_packet(32'hFF, 32'hFF, 6'd5, 20, lat, got, werr, rises);
    chk("bad_resp", 32'(got), 32'd1);
    chk("bad_latency", 32'(lat), 32'd1);
    chk("bad_werr", 32'(werr), 32'd1);
    chk("bad_tck_rises", 32'(rises), 32'd0);
    chk("bad_tap", 32'(tapState), 32'd1);
    @(posedge clk); #1;
    chk("bad_werr_pulse", 32'(bus.widthError), 32'd0);
    chk("bad_resp_pulse", 32'(bus.respValid), 32'd0);

    // Reset asserted during bit 10 of a 24-bit shift.
    wait_ready();
    rise_base          = rise_cnt;
    bus.jtagTestVector = 32'h00FF_FFFF;
    bus.jtagTms        = 32'h0;
    bus.vectorWidth    = 6'd24;
    bus.packetValid    = 1'b1;
    @(posedge clk); #1;
    bus.packetValid    = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rise_cnt - rise_base >= 10) break;
      @(posedge clk); #1;
    end
    chk("abort_reached_bit10", 32'(rise_cnt - rise_base), 32'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pre_tdi", 32'(tdi), 32'd1);
    chk("abort_pre_tap", 32'(tapState), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_tck", 32'(tck), 32'd0);
    chk("abort_tms", 32'(tms), 32'd1);
    chk("abort_tdi", 32'(tdi), 32'd0);
    chk("abort_ready", 32'(bus.packetReady), 32'd0);
    chk("abort_cap", bus.capturedTdo, 32'h0);
    chk("abort_tap", 32'(tapState), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    resp_seen = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (bus.respValid === 1'b1) resp_seen++;
    end
    chk("abort_no_resp", 32'(resp_seen), 32'd0);

    run_packet(32'h0000_0081, 32'h0, 6'd8, 200, lat, got, werr, rises);
    chk("after_abort_latency", 32'(lat), 32'd33);
    chk("after_abort_cap", bus.capturedTdo, 32'h0000_0081);
    chk("after_abort_tap", 32'(tapState), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
